// File: rtl/dsa_fetch_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dsa_fetch_arbiter
// Description : Round-robin arbiter that shares one pixel-fetch unit between
//               N_REQ interpolation lanes. It queues one request per lane,
//               issues one fetch at a time and returns a one-cycle done pulse
//               to the lane that owns the fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module dsa_fetch_arbiter #(
    parameter int N_REQ   = 4,
    parameter int COORD_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic [N_REQ-1:0]           req_i,
    input  logic [N_REQ*COORD_W-1:0]   req_x_i,
    input  logic [N_REQ*COORD_W-1:0]   req_y_i,
    output logic [N_REQ-1:0]           done_o,
    output logic                       fetch_req,
    output logic [COORD_W-1:0]         fetch_x,
    output logic [COORD_W-1:0]         fetch_y,
    input  logic                       fetch_done,
    output logic [$clog2(N_REQ)-1:0]   owner,
    output logic [N_REQ-1:0]           pending_o,
    output logic                       overrun,
    output logic                       busy
);

    localparam int c_OWNER_W = $clog2(N_REQ);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RESPOND = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [N_REQ-1:0]       pending_q, pending_d;
    logic [COORD_W-1:0]     x_q [N_REQ];
    logic [COORD_W-1:0]     x_d [N_REQ];
    logic [COORD_W-1:0]     y_q [N_REQ];
    logic [COORD_W-1:0]     y_d [N_REQ];
    logic [c_OWNER_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [c_OWNER_W-1:0]   owner_q, owner_d;
    logic [N_REQ-1:0]       done_q, done_d;
    logic                   fetch_req_q, fetch_req_d;
    logic [COORD_W-1:0]     fetch_x_q, fetch_x_d;
    logic [COORD_W-1:0]     fetch_y_q, fetch_y_d;
    logic                   overrun_q, overrun_d;
    logic                   busy_q, busy_d;

    logic [N_REQ-1:0]       w_clear;
    logic [c_OWNER_W:0]     w_sum;
    logic                   w_grant_vld;
    logic [c_OWNER_W-1:0]   w_grant_idx;
    logic [c_OWNER_W:0]     w_owner_inc;

    // Round-robin search: first pending lane starting at rr_ptr, wrapping.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_sum       = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_sum = {1'b0, rr_ptr_q} + (c_OWNER_W+1)'(i);
            if (w_sum >= (c_OWNER_W+1)'(N_REQ)) begin
                w_sum = w_sum - (c_OWNER_W+1)'(N_REQ);
            end
            if (!w_grant_vld && pending_q[w_sum[c_OWNER_W-1:0]]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = w_sum[c_OWNER_W-1:0];
            end
        end
    end

    // Request capture; a request arriving as its own lane is retired is
    // accepted (set wins) rather than flagged as an overrun.
    always_comb begin
        w_clear = '0;
        if (state_q == ST_RESPOND) begin
            w_clear[owner_q] = 1'b1;
        end
        pending_d = pending_q & ~w_clear;
        overrun_d = overrun_q;
        x_d       = x_q;
        y_d       = y_q;
        for (int k = 0; k < N_REQ; k++) begin
            if (req_i[k]) begin
                if (!pending_q[k] || w_clear[k]) begin
                    pending_d[k] = 1'b1;
                    x_d[k]       = req_x_i[k*COORD_W +: COORD_W];
                    y_d[k]       = req_y_i[k*COORD_W +: COORD_W];
                end else begin
                    overrun_d    = 1'b1;
                end
            end
        end
    end

    // Grant state machine next-state and registered-output decode.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        fetch_x_d   = fetch_x_q;
        fetch_y_d   = fetch_y_q;
        w_owner_inc = {1'b0, owner_q} + (c_OWNER_W+1)'(1);
        case (state_q)
            ST_IDLE: begin
                if (enable && w_grant_vld) begin
                    state_d   = ST_ISSUE;
                    owner_d   = w_grant_idx;
                    fetch_x_d = x_q[w_grant_idx];
                    fetch_y_d = y_q[w_grant_idx];
                end
            end
            ST_ISSUE: begin
                // A completion in the issue cycle counts as an immediate reply.
                state_d = fetch_done ? ST_RESPOND : ST_WAIT;
            end
            ST_WAIT: begin
                if (fetch_done) begin
                    state_d = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                state_d = ST_IDLE;
                if (w_owner_inc >= (c_OWNER_W+1)'(N_REQ)) begin
                    rr_ptr_d = '0;
                end else begin
                    rr_ptr_d = w_owner_inc[c_OWNER_W-1:0];
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        fetch_req_d = (state_d == ST_ISSUE);
        done_d      = '0;
        if (state_d == ST_RESPOND) begin
            done_d[owner_d] = 1'b1;
        end
        busy_d      = (state_d != ST_IDLE) || (pending_d != '0);
    end

    // All state and registered outputs; reset abandons any fetch in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pending_q   <= '0;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            done_q      <= '0;
            fetch_req_q <= 1'b0;
            fetch_x_q   <= '0;
            fetch_y_q   <= '0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
            for (int k = 0; k < N_REQ; k++) begin
                x_q[k] <= '0;
                y_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            done_q      <= done_d;
            fetch_req_q <= fetch_req_d;
            fetch_x_q   <= fetch_x_d;
            fetch_y_q   <= fetch_y_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
            for (int k = 0; k < N_REQ; k++) begin
                x_q[k] <= x_d[k];
                y_q[k] <= y_d[k];
            end
        end
    end

    assign done_o    = done_q;
    assign fetch_req = fetch_req_q;
    assign fetch_x   = fetch_x_q;
    assign fetch_y   = fetch_y_q;
    assign owner     = owner_q;
    assign pending_o = pending_q;
    assign overrun   = overrun_q;
    assign busy      = busy_q;

endmodule
`default_nettype wire
